// File: rtl/serial_sub9.sv
// Bit-serial two's-complement subtractor: A - B - borrow_in, one bit per clock, LSB first.
// Start/busy/done handshake; results are registered on the edge that enters DONE.
module serial_sub9 #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             br_next;

    // Full-adder cell with B inverted, expressed as difference/borrow.
    always_comb begin
        d       = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= borrow_in;
                        res   <= '0;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d, res[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff       <= {d, res[WIDTH-1:1]};
                        borrow_out <= br_next;
                        overflow   <= (a_msb != b_msb) & (d != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub9.sv
// Directed self-checking bench for serial_sub9 (WIDTH=9) with a small arithmetic model for random ops.
module tb_serial_sub9;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] a;
    logic [8:0] b;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [8:0] diff;
    logic       borrow_out;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int both_high = 0;

    serial_sub9 #(.WIDTH(9)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .borrow_in(borrow_in),
        .busy(busy),
        .done(done),
        .diff(diff),
        .borrow_out(borrow_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) both_high++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done; returns edges to done and busy cycles seen.
    task automatic run_op(input logic [8:0] av, input logic [8:0] bv, input logic bi,
                          output int lat, output int busy_cycles);
        a = av; b = bv; borrow_in = bi; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cycles++;
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [8:0] ed, input logic eb, input logic eo);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        int lat;
        int bc;
        int dones;
        logic [8:0] ra;
        logic [8:0] rb;
        logic       rbi;
        int sa;
        int sb;
        int r;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check_result("rst", 9'h000, 1'b0, 1'b0);
        rst = 1'b0;
        step();

        run_op(9'd5, 9'd3, 1'b0, lat, bc);
        check("basic_lat", lat, 9);
        check("basic_busycycles", bc, 9);
        check("basic_busy_in_done", 32'(busy), 0);
        check_result("basic", 9'h002, 1'b0, 1'b0);
        step();
        check("basic_done_pulse", 32'(done), 0);
        check("basic_hold", 32'(diff), 32'h002);

        run_op(9'd3, 9'd5, 1'b0, lat, bc);
        check("borrow1_lat", lat, 9);
        check_result("borrow1", 9'h1FE, 1'b1, 1'b0);

        run_op(9'd0, 9'd0, 1'b1, lat, bc);
        check_result("borrow2", 9'h1FF, 1'b1, 1'b0);

        run_op(9'h0FF, 9'h100, 1'b0, lat, bc);
        check_result("ovf1", 9'h1FF, 1'b1, 1'b1);

        run_op(9'h100, 9'h001, 1'b0, lat, bc);
        check_result("ovf2", 9'h0FF, 1'b0, 1'b1);

        // Start pulse during SHIFT must be ignored.
        step();
        a = 9'h010; b = 9'h003; borrow_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        a = 9'h1FF; b = 9'h0AA; borrow_in = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        lat = 4;
        while (!done && lat < 30) begin step(); lat++; end
        check("ignore_lat", lat, 9);
        check_result("ignore", 9'h00D, 1'b0, 1'b0);

        // Back-to-back: start asserted during the DONE cycle.
        run_op(9'h1AB, 9'h0CD, 1'b1, lat, bc);
        check("b2b_lat", lat, 9);
        check_result("b2b", 9'h0DD, 1'b0, 1'b1);

        // Reset at the fifth SHIFT cycle aborts the operation.
        step();
        a = 9'h055; b = 9'h011; borrow_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check_result("abort", 9'h000, 1'b0, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        run_op(9'h055, 9'h011, 1'b0, lat, bc);
        check("fresh_lat", lat, 9);
        check_result("fresh", 9'h044, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            ra  = 9'($urandom_range(0, 511));
            rb  = 9'($urandom_range(0, 511));
            rbi = 1'($urandom_range(0, 1));
            sa = ra[8] ? int'(ra) - 512 : int'(ra);
            sb = rb[8] ? int'(rb) - 512 : int'(rb);
            r  = sa - sb - int'(rbi);
            run_op(ra, rb, rbi, lat, bc);
            check("rand_lat", lat, 9);
            check_result("rand", 9'((int'(ra) - int'(rb) - int'(rbi)) & 511),
                         (int'(ra) < int'(rb) + int'(rbi)),
                         (r < -256) || (r > 255));
        end

        check("busy_done_exclusive", both_high, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
